// File: rtl/either_edge_pkg.sv
// Shared constants for the either-edge detector slice.
package either_edge_pkg;

    localparam logic        EDGE_RESET_LEVEL = 1'b0;
    localparam int unsigned EDGE_SYNC_STAGES = 2;

endpackage

// File: rtl/either_edge_detector_if.sv
// Level-in / strobe-out bundle for the either-edge detector.
interface either_edge_detector_if;

    logic din;
    logic either_edge;

    modport master (
        output din,
        input  either_edge
    );

    modport slave (
        input  din,
        output either_edge
    );

endinterface

// File: rtl/edge_sync2.sv
// Multi-flop synchronizer with synchronous active-low reset to a chosen level.
module edge_sync2
    import either_edge_pkg::*;
#(
    parameter logic        RESET_VAL = EDGE_RESET_LEVEL,
    parameter int unsigned STAGES    = EDGE_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/either_edge_detector.sv
// Registered one-cycle strobe on any change of din.
// Define EITHER_EDGE_SYNC_EN to put a 2-flop synchronizer in front of the detector.
module either_edge_detector
    import either_edge_pkg::*;
#(
    parameter logic RESET_LEVEL = EDGE_RESET_LEVEL
) (
    input  logic                 clk,
    input  logic                 rst,
    either_edge_detector_if.slave bus
);

    logic din_s;
    logic din_q;
    logic either_edge_q;

`ifdef EITHER_EDGE_SYNC_EN
    edge_sync2 #(
        .RESET_VAL (RESET_LEVEL),
        .STAGES    (EDGE_SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.din),
        .q   (din_s)
    );
`else
    assign din_s = bus.din;
`endif

    // Reset wins over a same-edge change; no pulse survives reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_q         <= RESET_LEVEL;
            either_edge_q <= 1'b0;
        end else begin
            din_q         <= din_s;
            either_edge_q <= din_s ^ din_q;
        end
    end

    assign bus.either_edge = either_edge_q;

endmodule

// File: tb/tb_either_edge_detector.sv
// Self-checking bench for either_edge_detector: directed cases plus random stimulus vs. a sample-history model.
module tb_either_edge_detector;

`ifdef EITHER_EDGE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic RL = 1'b0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic samp[$];
    logic exp_edge;

    either_edge_detector_if dut_if ();

    either_edge_detector #(
        .RESET_LEVEL (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // Model: output is high iff the value seen LAT samples ago differs from the one before it.
    task automatic model_update(input logic d, input logic r);
        if (!r) begin
            samp.delete();
            for (int i = 0; i <= LAT; i++) samp.push_back(RL);
            exp_edge = 1'b0;
        end else begin
            samp.push_back(d);
            while (samp.size() > LAT + 2) void'(samp.pop_front());
            exp_edge = samp[samp.size() - 1 - LAT] ^ samp[samp.size() - 2 - LAT];
        end
    endtask

    // lit < 0 means no hand-computed expectation for this cycle.
    task automatic step(input logic d, input logic r, input bit glitch, input string name,
                        input int lit);
        @(negedge clk);
        rst        = r;
        dut_if.din = d;
        if (glitch) begin
            #5 dut_if.din = ~d;
            #5 dut_if.din = d;
        end
        @(posedge clk);
        model_update(d, r);
        #1;
        check("model", dut_if.either_edge, exp_edge);
        if (lit >= 0) check(name, dut_if.either_edge, (lit != 0));
    endtask

    initial begin
        logic d;
        logic r;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        dut_if.din = 1'b0;

        // Reset held two cycles, then first cycle after release with din at reset level.
        step(1'b0, 1'b0, 1'b0, "reset0", 0);
        step(1'b0, 1'b0, 1'b0, "reset1", 0);
        for (int i = 0; i <= LAT; i++) step(1'b0, 1'b1, 1'b0, "post_reset", 0);

        // Rising edge: single pulse LAT cycles after the sampling edge.
        for (int i = 0; i < LAT + 3; i++) step(1'b1, 1'b1, 1'b0, "rise", (i == LAT) ? 1 : 0);
        // Falling edge.
        for (int i = 0; i < LAT + 3; i++) step(1'b0, 1'b1, 1'b0, "fall", (i == LAT) ? 1 : 0);

        // Alternate for 4 cycles, then hold low.
        for (int i = 0; i < LAT + 7; i++) begin
            d = (i < 4) ? ((i % 2) == 0) : 1'b0;
            step(d, 1'b1, 1'b0, "alternate", (i >= LAT && i < LAT + 4) ? 1 : 0);
        end

        // Glitch inside the low phase is never sampled.
        step(1'b0, 1'b1, 1'b1, "glitch", 0);
        for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, 1'b0, "glitch_after", 0);

        // Reset asserted while a pulse is showing clears it at that edge.
        for (int i = 0; i <= LAT; i++) step(1'b1, 1'b1, 1'b0, "pre_rst_pulse", (i == LAT) ? 1 : 0);
        step(1'b1, 1'b0, 1'b0, "rst_mid_pulse", 0);

        // Release with din away from the reset level: exactly one pulse.
        for (int i = 0; i < LAT + 3; i++) step(1'b1, 1'b1, 1'b0, "release_high", (i == LAT) ? 1 : 0);

        // Random stimulus with occasional reset.
        for (int i = 0; i < 400; i++) begin
            d = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 19) != 0);
            step(d, r, 1'($urandom_range(0, 7) == 0), "random", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
